// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART-to-ALU front-end: collects A, B, operator bytes, returns result to TX.
// Optional inter-byte timeout compiled in with UART_ALU_IF_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPERADOR    = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    output logic [NB_DATA-1:0]     o_dato_a,
    output logic [NB_DATA-1:0]     o_dato_b,
    output logic [NB_OPERADOR-1:0] o_operador,
    output logic                   o_alu_valid,
    input  logic [NB_DATA-1:0]     i_alu_resultado,
    input  logic                   i_alu_done,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_rx_drop,
    output logic                   o_timeout
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_VALID,
        ST_TX_START,
        ST_WAIT_TX
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_DATA-1:0]     dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]     dato_b_q, dato_b_d;
    logic [NB_OPERADOR-1:0] operador_q, operador_d;
    logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
    logic                   alu_valid_q, alu_valid_d;
    logic                   tx_start_q, tx_start_d;
    logic                   busy_q, busy_d;
    logic                   rx_drop_q, rx_drop_d;
    logic                   timeout_hit;

`ifdef UART_ALU_IF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             cnt_run;

    assign cnt_run     = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign timeout_hit = cnt_run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter clears on any accepted byte, on expiry, and everywhere outside B/OP.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit && !i_rx_done;
            if (cnt_run && !i_rx_done && !timeout_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        operador_d = operador_q;
        tx_data_d  = tx_data_q;
        rx_drop_d  = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    dato_a_d = i_rx_data;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    dato_b_d = i_rx_data;
                    state_d  = ST_WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    operador_d = i_rx_data[NB_OPERADOR-1:0];
                    state_d    = ST_VALID;
                end else if (timeout_hit) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_VALID: begin
                rx_drop_d = i_rx_done;
                if (i_alu_done) begin
                    tx_data_d = i_alu_resultado;
                    state_d   = ST_TX_START;
                end
            end
            ST_TX_START: begin
                rx_drop_d = i_rx_done;
                state_d   = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A byte racing tx_done is dropped, never taken as the next A.
                rx_drop_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
        alu_valid_d = (state_d == ST_VALID);
        tx_start_d  = (state_d == ST_TX_START);
        busy_d      = (state_d != ST_WAIT_A);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_WAIT_A;
            dato_a_q    <= '0;
            dato_b_q    <= '0;
            operador_q  <= '0;
            tx_data_q   <= '0;
            alu_valid_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dato_a_q    <= dato_a_d;
            dato_b_q    <= dato_b_d;
            operador_q  <= operador_d;
            tx_data_q   <= tx_data_d;
            alu_valid_q <= alu_valid_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    assign o_dato_a    = dato_a_q;
    assign o_dato_b    = dato_b_q;
    assign o_operador  = operador_q;
    assign o_tx_data   = tx_data_q;
    assign o_alu_valid = alu_valid_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - directed and randomized bench for uart_alu_interface with an ALU stand-in.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] dato_a, dato_b, tx_data, alu_res;
    logic [5:0] operador;
    logic       alu_valid, alu_done, tx_start, tx_done, busy, rx_drop, timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int starts  = 0;
    int tmo_cnt = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .NB_DATA(8),
        .NB_OPERADOR(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .o_dato_a(dato_a),
        .o_dato_b(dato_b),
        .o_operador(operador),
        .o_alu_valid(alu_valid),
        .i_alu_resultado(alu_res),
        .i_alu_done(alu_done),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done(tx_done),
        .o_busy(busy),
        .o_rx_drop(rx_drop),
        .o_timeout(timeout)
    );

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return sa >>> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = ref_alu(dato_a, dato_b, operador);

    always @(posedge clk) begin
        if (tx_start) starts++;
        if (timeout) tmo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // mode: 0 plain, 1 stray byte during WAIT_TX, 2 stray byte together with tx_done
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int stall, input int mode, input logic [7:0] exp);
        int s0;
        s0 = starts;
        alu_done = (stall == 0);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check("alu_valid", alu_valid, 1);
        check("dato_a", dato_a, a);
        check("dato_b", dato_b, b);
        check("operador", operador, op[5:0]);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("valid_hold", alu_valid, 1);
            check("no_early_start", tx_start, 0);
        end
        alu_done = 1'b1;
        @(negedge clk);
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, exp);
        check("valid_end", alu_valid, 0);
        @(negedge clk);
        check("tx_start_pulse", tx_start, 0);
        check("busy_wait_tx", busy, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (mode == 1) begin
            send_byte(8'hAA);
            check("rx_drop", rx_drop, 1);
            check("dato_a_kept", dato_a, a);
            check("busy_after_drop", busy, 1);
        end
        rx_data = 8'h5C;
        rx_done = (mode == 2);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        rx_done = 1'b0;
        check("busy_idle", busy, 0);
        if (mode == 2) begin
            check("rx_drop_race", rx_drop, 1);
            check("dato_a_race", dato_a, a);
        end
        check("one_start", starts - s0, 1);
    endtask

    initial begin
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        logic [7:0] a, b, op;
        rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; alu_done = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", alu_valid, 0);
        check("rst_tx_data", tx_data, 0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 8'h20, 0, 0, 8'h08);
        run_op(8'h03, 8'h05, 8'h22, 0, 0, 8'hFE);
        check("op_sub", operador, 6'h22);
        run_op(8'h80, 8'h02, 8'hC3, 0, 0, 8'hE0);
        check("op_strip", operador, 6'h03);
        run_op(8'h09, 8'h06, 8'h24, 2, 1, 8'h00);
        run_op(8'h01, 8'h01, 8'h20, 0, 0, 8'h02);
        run_op(8'h10, 8'h0F, 8'h22, 1, 2, 8'h01);

        // Reset with an operation half collected
        send_byte(8'h07);
        send_byte(8'h09);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_a", dato_a, 0);
        check("rst2_b", dato_b, 0);
        check("rst2_busy", busy, 0);
        check("rst2_drop", rx_drop, 0);
        run_op(8'h01, 8'h02, 8'h20, 0, 0, 8'h03);

        // Inter-byte timeout
        tmo_cnt = 0;
        send_byte(8'h11);
        repeat (20) @(negedge clk);
`ifdef UART_ALU_IF_TIMEOUT_EN
        check("timeout_pulses", tmo_cnt, 1);
        check("timeout_idle", busy, 0);
`else
        check("no_timeout", tmo_cnt, 0);
        check("still_wait_b", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        run_op(8'h04, 8'h04, 8'h20, 0, 0, 8'h08);

        for (int i = 0; i < 30; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom_range(0, 9));
            op = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
            run_op(a, b, op, $urandom_range(0, 3), $urandom_range(0, 2), ref_alu(a, b, op[5:0]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
